// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-event input and register-write output bundle of the UART frame
// controller; master drives bytes, slave is the frame controller.
interface uart_rx_frame_ctrl_if;
  logic       rx_evt_i;
  logic [7:0] rx_data_i;
  logic       wr_en_o;
  logic [7:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       frame_done_o;
  logic       frame_err_o;
  logic [1:0] err_code_o;
  logic       busy_o;

  modport master (
    output rx_evt_i, rx_data_i,
    input  wr_en_o, wr_addr_o, wr_data_o,
    input  frame_done_o, frame_err_o, err_code_o, busy_o
  );

  modport slave (
    input  rx_evt_i, rx_data_i,
    output wr_en_o, wr_addr_o, wr_data_o,
    output frame_done_o, frame_err_o, err_code_o, busy_o
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART frame controller: parses HEADER/ADDR/LEN/payload[/CHK] byte events,
// buffers payload and commits it as one register write per cycle.
// Ports: clk, rst (async, active-high), bus (slave): rx_evt_i/rx_data_i in;
// wr_en_o/wr_addr_o/wr_data_o, frame_done_o, frame_err_o, err_code_o,
// busy_o out. Define UART_FRAME_CHK_EN to expect and verify a CHK byte.
module uart_rx_frame_ctrl #(
  parameter logic [31:0] MODULE_CLK_RATE   = 32'd100000000,
  parameter logic [31:0] UART_BAUDCLK_RATE = 32'd115200,
  parameter int unsigned TIMEOUT_BYTES     = 4,
  parameter logic [7:0]  HEADER            = 8'hA5,
  parameter int unsigned MAX_LEN           = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_rx_frame_ctrl_if.slave  bus
);
  localparam int unsigned BAUD_DIV =
    MODULE_CLK_RATE / UART_BAUDCLK_RATE;
  localparam int unsigned TO_LIM =
    TIMEOUT_BYTES * 10 * BAUD_DIV;
  localparam int unsigned CW =
    (TO_LIM > 1) ? $clog2(TO_LIM) : 1;
  localparam int unsigned IW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW =
    (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(TO_LIM - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHK,
    S_COMMIT
  } state_e;

  state_e          state_q;
  logic [7:0]      addr_q;
  logic [IW-1:0]   len_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   cidx_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      buf_q [MAX_LEN];
  logic            wr_en_q;
  logic [7:0]      wr_addr_q;
  logic [7:0]      wr_data_q;
  logic            done_q;
  logic            err_q;
  logic [1:0]      code_q;
`ifdef UART_FRAME_CHK_EN
  logic [7:0]      chk_q;
`endif

  logic            rx_evt;
  logic [7:0]      rx_data;
  logic            timed;
  logic            to_hit;
  logic            last_d;

  assign rx_evt  = bus.rx_evt_i;
  assign rx_data = bus.rx_data_i;

  assign timed = (state_q == S_ADDR) || (state_q == S_LEN) ||
                 (state_q == S_DATA) || (state_q == S_CHK);

  // Counter holds the number of silent cycles since the last byte;
  // the error fires on the edge that would make it reach the limit.
  assign to_hit = timed && !rx_evt && (cnt_q == CNT_LAST);

  assign last_d = ((idx_q + IDX_ONE) == len_q);

  // Payload storage carries no reset: contents are don't-care.
  always_ff @(posedge clk) begin
    if (state_q == S_DATA && rx_evt)
      buf_q[idx_q[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      cidx_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'd0;
`ifdef UART_FRAME_CHK_EN
      chk_q     <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= (timed && !rx_evt) ? cnt_q + CNT_ONE : '0;

      if (to_hit) begin
        err_q   <= 1'b1;
        code_q  <= 2'd2;
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (rx_evt && rx_data == HEADER)
              state_q <= S_ADDR;
          end
          S_ADDR: begin
            if (rx_evt) begin
              addr_q  <= rx_data;
`ifdef UART_FRAME_CHK_EN
              chk_q   <= rx_data;
`endif
              state_q <= S_LEN;
            end
          end
          S_LEN: begin
            if (rx_evt) begin
              if (rx_data == 8'd0 || rx_data > LEN_MAX) begin
                err_q   <= 1'b1;
                code_q  <= 2'd0;
                state_q <= S_IDLE;
              end else begin
                len_q   <= rx_data[IW-1:0];
                idx_q   <= '0;
`ifdef UART_FRAME_CHK_EN
                chk_q   <= chk_q ^ rx_data;
`endif
                state_q <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (rx_evt) begin
              idx_q <= idx_q + IDX_ONE;
`ifdef UART_FRAME_CHK_EN
              chk_q <= chk_q ^ rx_data;
              if (last_d)
                state_q <= S_CHK;
`else
              // First write issues on the next edge; for a one-byte
              // payload the buffer is not yet loaded, so bypass it.
              if (last_d) begin
                state_q   <= S_COMMIT;
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= (idx_q == '0) ? rx_data : buf_q[0];
                cidx_q    <= IDX_ONE;
              end
`endif
            end
          end
`ifdef UART_FRAME_CHK_EN
          S_CHK: begin
            if (rx_evt) begin
              if (rx_data == chk_q) begin
                state_q   <= S_COMMIT;
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= buf_q[0];
                cidx_q    <= IDX_ONE;
              end else begin
                err_q   <= 1'b1;
                code_q  <= 2'd1;
                state_q <= S_IDLE;
              end
            end
          end
`endif
          S_COMMIT: begin
            // Late bytes are dropped; the burst is not disturbed.
            if (rx_evt) begin
              err_q  <= 1'b1;
              code_q <= 2'd3;
            end
            if (cidx_q == len_q) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr_q + 8'(cidx_q);
              wr_data_q <= buf_q[cidx_q[AW-1:0]];
              cidx_q    <= cidx_q + IDX_ONE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.wr_en_o      = wr_en_q;
  assign bus.wr_addr_o    = wr_addr_q;
  assign bus.wr_data_o    = wr_data_q;
  assign bus.frame_done_o = done_q;
  assign bus.frame_err_o  = err_q;
  assign bus.err_code_o   = code_q;
  assign bus.busy_o       = (state_q != S_IDLE);
endmodule
